// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register: output register plus one skid entry, valid/ready on both sides.
// in_ready depends only on state and rst, so out_ready never reaches it combinationally.
module pipe_stage_skid #(
   parameter int CTRL_W = 6,
   parameter int DATA_W = 87
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

   state_t state, state_nx;

   logic [CTRL_W-1:0] ctrl_q, skid_ctrl_q;
   logic [DATA_W-1:0] data_q, skid_data_q;
   logic in_xfer, out_xfer;
   logic ld_out, ld_skid, sel_skid;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst)       state <= EMPTY;
      else if (flush) state <= EMPTY;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ld_out   = 1'b0;
      ld_skid  = 1'b0;
      sel_skid = 1'b0;
      case (state)
         EMPTY: if (in_xfer) begin
            ld_out   = 1'b1;
            state_nx = HALF;
         end
         HALF: begin
            if (in_xfer && out_xfer) begin
               ld_out = 1'b1;
            end else if (in_xfer) begin
               ld_skid  = 1'b1;
               state_nx = FULL;
            end else if (out_xfer) begin
               state_nx = EMPTY;
            end
         end
         FULL: if (out_xfer) begin
            ld_out   = 1'b1;
            sel_skid = 1'b1;
            state_nx = HALF;
         end
         default: state_nx = EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state != EMPTY);
      in_ready  = rst & (state != FULL);
      occupancy = (state == FULL) ? 2'd2 : (state == HALF) ? 2'd1 : 2'd0;
      out_ctrl  = out_valid ? ctrl_q : '0;
      out_data  = data_q;
   end

   // Flush clears only ctrl: a bubble must never carry enables, data may stay stale.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_q      <= '0;
         data_q      <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else if (flush) begin
         ctrl_q      <= '0;
         skid_ctrl_q <= '0;
      end else begin
         if (ld_out) begin
            ctrl_q <= sel_skid ? skid_ctrl_q : in_ctrl;
            data_q <= sel_skid ? skid_data_q : in_data;
         end
         if (ld_skid) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
         end
      end
   end

endmodule
